// File: rtl/mul_pkg.sv
// Shared definitions for the multiply issue controller.
// Contents:
//   - MUL_LAT_DEFAULT : default multiplier latency in cycles
//   - mul_op_e        : request op encodings
//   - mul_state_e     : issue FSM state encoding
//   - op_is_signed    : selects signed multiply for MULT/MUL/MADD
package mul_pkg;

  localparam int unsigned MUL_LAT_DEFAULT = 2;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MUL   = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MADD  = 3'd5,
    OP_MADDU = 3'd6,
    OP_RSVD  = 3'd7
  } mul_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mul_state_e;

  function automatic logic op_is_signed(input mul_op_e op);
    return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   hi_we, lo_we       : MTHI / MTLO write strobes, data on wdata
//   wdata              : 32-bit move-to data
//   ld_we              : load {hi,lo} with mul_result (MULT/MULTU)
//   acc_we             : accumulate {hi,lo} += mul_result (MADD/MADDU),
//                        present only when MUL_ACC_EN is defined
//   mul_result         : 64-bit product
//   hi, lo             : register outputs
// Build option: MUL_ACC_EN enables the 64-bit accumulate adder.
module hilo_reg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        ld_we,
`ifdef MUL_ACC_EN
  input  logic        acc_we,
`endif
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (ld_we) begin
      {hi, lo} <= mul_result;
`ifdef MUL_ACC_EN
    end else if (acc_we) begin
      // Single 64-bit add so the carry out of lo propagates into hi.
      {hi, lo} <= {hi, lo} + mul_result;
`endif
    end else begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue controller: accepts multiply/move requests, drives an
// external fixed-latency multiplier, and retires results to HI/LO or to a
// GPR writeback port.
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   flush                  : exception flush, drops/aborts the current op
//   req_valid/req_ready    : issue handshake
//   req_op/src1/src2/dst   : request payload
//   mul_sign/op1/op2       : multiplier operand drive (held during WAIT)
//   mul_result             : 64-bit product from the multiplier
//   busy                   : stall request while a multiply is in flight
//   hi, lo                 : architectural HI/LO
//   wb_valid/dst/data      : one-cycle MUL writeback
// Build option: MUL_ACC_EN enables MADD/MADDU; otherwise they are no-ops.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [4:0]  req_dst,
  output logic        mul_sign,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic [63:0] mul_result,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wb_valid,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_data
);

  mul_state_e  state_q, state_d;
  logic [3:0]  cnt_q;
  mul_op_e     op_q;
  logic [31:0] src1_q, src2_q;
  logic [4:0]  dst_q;
  logic        sign_q;

  mul_op_e     op_in;
  logic        accept;
  logic        starts_mul;
  logic        complete;
  logic        mt_hi_we, mt_lo_we, ld_we;
`ifdef MUL_ACC_EN
  logic        acc_we;
`endif

  assign op_in     = mul_op_e'(req_op);
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_WAIT);
  assign accept    = req_valid && req_ready && !flush;
  assign complete  = (state_q == ST_WAIT) && (cnt_q == 4'd1) && !flush;

  always_comb begin
    starts_mul = 1'b0;
    case (op_in)
      OP_MULT, OP_MULTU, OP_MUL: starts_mul = 1'b1;
`ifdef MUL_ACC_EN
      OP_MADD, OP_MADDU:         starts_mul = 1'b1;
`endif
      default:                   starts_mul = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && starts_mul) state_d = ST_WAIT;
      ST_WAIT: if (flush || cnt_q == 4'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mt_hi_we = accept && (op_in == OP_MTHI);
  assign mt_lo_we = accept && (op_in == OP_MTLO);
  assign ld_we    = complete && ((op_q == OP_MULT) || (op_q == OP_MULTU));
`ifdef MUL_ACC_EN
  assign acc_we   = complete && ((op_q == OP_MADD) || (op_q == OP_MADDU));
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      sign_q   <= 1'b0;
      wb_valid <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= complete && (op_q == OP_MUL);
      if (complete && (op_q == OP_MUL)) begin
        wb_dst  <= dst_q;
        wb_data <= mul_result[31:0];
      end
      if (accept && starts_mul) begin
        op_q   <= op_in;
        src1_q <= req_src1;
        src2_q <= req_src2;
        dst_q  <= req_dst;
        sign_q <= op_is_signed(op_in);
        cnt_q  <= 4'(MUL_LAT);
      end else if (state_q == ST_WAIT) begin
        cnt_q  <= flush ? '0 : cnt_q - 4'd1;
      end
    end
  end

  assign mul_sign = sign_q;
  assign mul_op1  = src1_q;
  assign mul_op2  = src2_q;

  hilo_reg u_hilo (
    .clk        (clk),
    .resetn     (resetn),
    .hi_we      (mt_hi_we),
    .lo_we      (mt_lo_we),
    .wdata      (req_src1),
    .ld_we      (ld_we),
`ifdef MUL_ACC_EN
    .acc_we     (acc_we),
`endif
    .mul_result (mul_result),
    .hi         (hi),
    .lo         (lo)
  );

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic [4:0]  req_dst = '0;
  logic        mul_sign;
  logic [31:0] mul_op1, mul_op2;
  logic [63:0] mul_result;
  logic        busy;
  logic [31:0] hi, lo;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
    .mul_sign(mul_sign), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_result(mul_result), .busy(busy), .hi(hi), .lo(lo),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data)
  );

  // External multiplier stand-in, driven from the operand bus.
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  assign sprod = $signed(mul_op1) * $signed(mul_op2);
  assign uprod = {32'b0, mul_op1} * {32'b0, mul_op2};
  assign mul_result = mul_sign ? sprod : uprod;

  typedef struct {
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wb;
    logic [4:0]  dst;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: retires one scoreboard entry each time busy falls.
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) begin
      busy_cnt++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
        check("ret_hi", {32'b0, hi}, {32'b0, e.hi});
        check("ret_lo", {32'b0, lo}, {32'b0, e.lo});
        check("ret_wb_valid", {63'b0, wb_valid}, {63'b0, e.wb});
        if (e.wb) begin
          check("ret_wb_data", {32'b0, wb_data}, {32'b0, e.data});
          check("ret_wb_dst", {59'b0, wb_dst}, {59'b0, e.dst});
        end
      end
      busy_cnt = 0;
    end else if (wb_valid === 1'b1) begin
      check("wb_spurious", 1, 0);
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] dst);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = s1;
    req_src2  = s2;
    req_dst   = dst;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 20);
    if (busy !== 1'b0) begin
      check("idle_timeout", {63'b0, busy}, 0);
    end
  endtask

  initial begin
    // Reset
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {63'b0, req_ready}, 1);
    check("rst_busy", {63'b0, busy}, 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_wb", {26'b0, wb_valid, wb_dst, wb_data}, 0);
    check("rst_mul_drive", {mul_sign, mul_op1, mul_op2}, 0);

    // MULT -1 x 2
    sb.push_back('{2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5'd0, 32'd0});
    issue(3'd0, 32'hFFFFFFFF, 32'h2, 5'd0);
    @(negedge clk);
    check("mult_sign", {63'b0, mul_sign}, 1);
    check("mult_op1", {32'b0, mul_op1}, 64'hFFFFFFFF);
    wait_idle();

    // MULTU 0xFFFFFFFF x 2
    sb.push_back('{2, 32'h1, 32'hFFFFFFFE, 1'b0, 5'd0, 32'd0});
    issue(3'd1, 32'hFFFFFFFF, 32'h2, 5'd0);
    @(negedge clk);
    check("multu_ready_wait", {63'b0, req_ready}, 0);
    check("multu_sign", {63'b0, mul_sign}, 0);
    wait_idle();

    // MUL 7 x 6 -> r5, hi/lo untouched
    sb.push_back('{2, 32'h1, 32'hFFFFFFFE, 1'b1, 5'd5, 32'd42});
    issue(3'd2, 32'd7, 32'd6, 5'd5);
    wait_idle();
    @(negedge clk);
    check("mul_wb_one_cycle", {63'b0, wb_valid}, 0);

    // MTLO then MULT flushed on its completion edge
    issue(3'd4, 32'h1234, 32'h0, 5'd0);
    @(negedge clk);
    check("mtlo_lo", {32'b0, lo}, 64'h1234);
    check("mtlo_no_busy", {63'b0, busy}, 0);
    sb.push_back('{2, 32'h1, 32'h1234, 1'b0, 5'd0, 32'd0});
    issue(3'd0, 32'd3, 32'd4, 5'd0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready", {63'b0, req_ready}, 1);

    // Request presented with flush high is dropped
    @(negedge clk);
    flush = 1'b1;
    issue(3'd3, 32'hDEAD, 32'h0, 5'd0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_drop_hi", {32'b0, hi}, 64'h1);

    // MTHI 0, MTLO all-ones, MADDU 1 x 1
    issue(3'd3, 32'h0, 32'h0, 5'd0);
    issue(3'd4, 32'hFFFFFFFF, 32'h0, 5'd0);
`ifdef MUL_ACC_EN
    sb.push_back('{2, 32'h1, 32'h0, 1'b0, 5'd0, 32'd0});
    issue(3'd6, 32'd1, 32'd1, 5'd0);
    wait_idle();
`else
    issue(3'd6, 32'd1, 32'd1, 5'd0);
    @(negedge clk);
    check("maddu_off_busy", {63'b0, busy}, 0);
    check("maddu_off_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    // Reserved op is a no-op
    issue(3'd7, 32'h5, 32'h5, 5'd1);
    @(negedge clk);
    check("rsvd_no_busy", {63'b0, busy}, 0);

    // Reset for one cycle in the middle of a MUL
    sb.push_back('{1, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0});
    issue(3'd2, 32'd5, 32'd5, 5'd3);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {63'b0, req_ready}, 1);
    check("rst_mid_busy", {63'b0, busy}, 0);
    repeat (3) @(negedge clk);
    check("rst_mid_hilo", {hi, lo}, 0);

    check("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, multiplier latency in cycles (legal 1..8).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, pipeline exception flush.
REQ-005 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the issue handshake.
REQ-006 SHALL have port req_op, input, 3, operation: 0 MULT, 1 MULTU, 2 MUL, 3 MTHI, 4 MTLO, 5 MADD, 6 MADDU, 7 reserved.
REQ-007 SHALL have ports req_src1 and req_src2 (input, 32, operands) and req_dst (input, 5, GPR destination for MUL).
REQ-008 SHALL have ports mul_sign (output, 1), mul_op1 and mul_op2 (output, 32), the multiplier operand drive.
REQ-009 SHALL have port mul_result, input, 64, full product returned by the multiplier.
REQ-010 SHALL have port busy, output, 1, pipeline stall request.
REQ-011 SHALL have ports hi and lo, output, 32, architectural HI/LO.
REQ-012 SHALL have ports wb_valid (output, 1), wb_dst (output, 5) and wb_data (output, 32), the MUL GPR writeback.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT; req_ready = (state==IDLE); busy = (state==WAIT).
REQ-014 SHALL accept a request on an edge where req_valid && req_ready && !flush; with flush high, the request is dropped.
REQ-015 SHALL execute ops 3/4 in one cycle: hi<=src1 (MTHI) or lo<=src1 (MTLO) on the accept edge, stay IDLE.
REQ-016 SHALL, on accepting ops 0/1/2/5/6, register src1/src2/op/dst, load cycle counter with MUL_LAT, enter WAIT.
REQ-017 SHALL hold mul_op1/mul_op2/mul_sign stable from the registered copies throughout WAIT; mul_sign=1 for ops 0/2/5, else 0.
REQ-018 SHALL decrement the counter each WAIT cycle and, on the edge where counter==1, complete and return to IDLE (completion exactly MUL_LAT edges after accept).
REQ-019 SHALL on completion of MULT/MULTU load {hi,lo}<=mul_result.
REQ-020 SHALL on completion of MUL pulse wb_valid for exactly one cycle with wb_data=mul_result[31:0], wb_dst=registered dst; hi/lo unchanged.
REQ-021 SHALL on completion of MADD/MADDU load {hi,lo}<={hi,lo}+mul_result modulo 2^64 (carry from lo into hi).
REQ-022 SHALL treat op 7 as a single-cycle no-op.
REQ-023 SHALL on flush in WAIT, including the completion edge, abort: return to IDLE, no hi/lo update, no wb_valid.
REQ-024 SHALL keep wb_valid low in all cycles other than REQ-020 pulses; the next request is acceptable on the cycle after completion.

Reset
REQ-025 SHALL on resetn low force IDLE, counter=0, hi=0, lo=0, wb_valid=0, wb_dst=0, wb_data=0, busy=0, mul_op1=mul_op2=0, mul_sign=0.
REQ-026 SHALL on reset mid-WAIT discard the operation with no hi/lo or writeback effect; req_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-027 SHALL gate MADD/MADDU with macro MUL_ACC_EN: defined -> REQ-021 behaviour; undefined -> ops 5/6 behave as op 7 (single-cycle no-op, no accumulator adder).

Structure
REQ-028 SHALL place op encodings, FSM state encoding and the MUL_LAT default in shared package mul_pkg.
REQ-029 SHALL implement HI/LO storage, MTHI/MTLO writes and the accumulate adder in one sub-module hilo_reg.

Verification
REQ-030 SHALL test MULT 0xFFFFFFFF x 0x00000002, MUL_LAT=2 -> busy 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 SHALL test MULTU 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; req_ready low during WAIT.
REQ-032 SHALL test MUL 7 x 6, dst=5 -> single wb_valid pulse, wb_data=42, wb_dst=5, hi/lo unchanged.
REQ-033 SHALL test MTLO 0x1234 then MULT with flush asserted on the completion edge -> lo=0x1234, no wb_valid, IDLE next cycle.
REQ-034 SHALL test, with MUL_ACC_EN, MTHI 0 and MTLO 0xFFFFFFFF then MADDU 1 x 1 -> hi=1, lo=0; without the macro -> hi=0, lo=0xFFFFFFFF, no busy.
REQ-035 SHALL test resetn low for one cycle mid-WAIT -> hi=lo=0, busy=0, no wb_valid, req_ready=1.
